// File: rtl/alu_issue_ctrl_if.sv
// ALU op encoding plus the issue/ALU interface bundle shared by the execute stage.
// Latency: none (types and wiring only).
// Backpressure: none; the interface carries a purely combinational request/response.
package cpu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } aluop_t;
endpackage

interface alu_if;
  import cpu_pkg::*;
  aluop_t      op;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [31:0] ALUResult;
  logic        zero;
  logic        negative;

  // Issue side drives the request and reads back the combinational result.
  modport issue (output op, output inputA, output inputB,
                 input ALUResult, input zero, input negative);
  // ALU side answers the request in the same cycle.
  modport alu (input op, input inputA, input inputB,
               output ALUResult, output zero, output negative);
endinterface

// File: rtl/alu_issue_ctrl.sv
// RV32I execute-stage driver: decodes an instruction, drives the ALU, resolves branches.
// Latency: instruction registered at accept, result valid two cycles after it is presented; 1 op / 2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there. Optional ALU_ISSUE_PERF_EN adds perf counters.
module alu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  alu_if.issue            aluif,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_br_taken
`endif
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state, state_nxt;

  // Instruction fields captured at accept.
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q;

  // Result fields captured at the end of EXEC.
  logic [XLEN-1:0] res_q, target_q;
  logic [4:0]      rd_q;
  logic            wen_q, taken_q, ill_q;

  // Decode results for the registered instruction.
  aluop_t          dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_ill, dec_br, br_taken;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm_i, imm_u, imm_b;
  logic            accept, out_fire;

  assign opcode = instr_q[6:0];
  assign rd_f   = instr_q[11:7];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_b  = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; reset from any state drops whatever was in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake signals; reset forces both sides idle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? S_EXEC : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  // Operand capture on an input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (accept) begin
      instr_q <= in_instr;
      pc_q    <= in_pc;
      rs1_q   <= in_rs1_data;
      rs2_q   <= in_rs2_data;
    end
  end

  // Decode: ALU op and operands; shifts take only the low five bits of the amount.
  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = rs1_q;
    dec_b   = rs2_q;
    dec_ill = 1'b0;
    dec_br  = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_op = ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_op = ALU_SRA;
        end else begin
          dec_ill = 1'b1;
        end
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec_b = {{(XLEN-5){1'b0}}, rs2_q[4:0]};
      end
      OPC_I: begin
        dec_b = imm_i;
        case (funct3)
          3'b000: dec_op = ALU_ADD;
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          3'b001: begin
            dec_op = ALU_SLL;
            dec_b  = {{(XLEN-5){1'b0}}, instr_q[24:20]};
            if (funct7 != 7'b0000000) dec_ill = 1'b1;
          end
          default: begin
            dec_b = {{(XLEN-5){1'b0}}, instr_q[24:20]};
            if (funct7 == 7'b0000000)      dec_op  = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_op  = ALU_SRA;
            else                           dec_ill = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        dec_a = '0;
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = pc_q;
        dec_b = imm_u;
      end
      OPC_BRANCH: begin
        dec_br = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_op  = ALU_SUB;
          3'b100, 3'b101: dec_op  = ALU_SLT;
          3'b110, 3'b111: dec_op  = ALU_SLTU;
          default:        dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
    end
  end

  // ALU request is only live in EXEC; otherwise a quiet ADD of zeros.
  always_comb begin
    aluif.op     = ALU_ADD;
    aluif.inputA = '0;
    aluif.inputB = '0;
    if (state == S_EXEC && !rst) begin
      aluif.op     = dec_op;
      aluif.inputA = dec_a;
      aluif.inputB = dec_b;
    end
  end

  // Branch outcome from the ALU flags: zero for BEQ/BNE, set-less-than result otherwise.
  always_comb begin
    br_taken = 1'b0;
    if (dec_br && !dec_ill) begin
      case (funct3)
        3'b000:         br_taken = aluif.zero;
        3'b001:         br_taken = !aluif.zero;
        3'b100, 3'b110: br_taken = (aluif.ALUResult == XLEN'(1));
        3'b101, 3'b111: br_taken = (aluif.ALUResult == '0);
        default:        br_taken = 1'b0;
      endcase
    end
  end

  // Result capture at the end of EXEC; held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      target_q <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      taken_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else if (state == S_EXEC) begin
      res_q    <= (dec_br || dec_ill) ? '0 : aluif.ALUResult;
      target_q <= pc_q + imm_b;
      wen_q    <= !dec_br && !dec_ill && (rd_f != 5'd0);
      rd_q     <= (dec_br || dec_ill) ? 5'd0 : rd_f;
      taken_q  <= br_taken;
      ill_q    <= dec_ill;
    end
  end

  // Outputs read as zero while reset is asserted.
  always_comb begin
    out_result    = rst ? '0   : res_q;
    out_rd        = rst ? 5'd0 : rd_q;
    out_wen       = rst ? 1'b0 : wen_q;
    out_br_taken  = rst ? 1'b0 : taken_q;
    out_br_target = rst ? '0   : target_q;
    out_illegal   = rst ? 1'b0 : ill_q;
  end

`ifdef ALU_ISSUE_PERF_EN
  // Completed-op and taken-branch counters, counted on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops      <= '0;
      perf_br_taken <= '0;
    end else if (out_fire) begin
      perf_ops <= perf_ops + 32'd1;
      if (out_br_taken) perf_br_taken <= perf_br_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, multi-cycle corner sequences, randomized ops.
// Latency: results checked two cycles after presentation.
// Backpressure: exercised with held out_ready and random output stalls.
module tb_alu_issue_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;
  logic        out_wen, out_br_taken, out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_br_taken;
  int          exp_ops = 0, exp_tk = 0;
`endif

  alu_if aluif_i ();

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .aluif(aluif_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wen(out_wen), .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_br_taken(perf_br_taken)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU the block drives.
  logic [31:0] alu_r;
  always_comb begin
    case (aluif_i.op)
      ALU_ADD:  alu_r = aluif_i.inputA + aluif_i.inputB;
      ALU_SUB:  alu_r = aluif_i.inputA - aluif_i.inputB;
      ALU_SLL:  alu_r = aluif_i.inputA << aluif_i.inputB[4:0];
      ALU_SLT:  alu_r = ($signed(aluif_i.inputA) < $signed(aluif_i.inputB)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_r = (aluif_i.inputA < aluif_i.inputB) ? 32'd1 : 32'd0;
      ALU_XOR:  alu_r = aluif_i.inputA ^ aluif_i.inputB;
      ALU_SRL:  alu_r = aluif_i.inputA >> aluif_i.inputB[4:0];
      ALU_SRA:  alu_r = $signed(aluif_i.inputA) >>> aluif_i.inputB[4:0];
      ALU_OR:   alu_r = aluif_i.inputA | aluif_i.inputB;
      ALU_AND:  alu_r = aluif_i.inputA & aluif_i.inputB;
      default:  alu_r = 32'd0;
    endcase
    aluif_i.ALUResult = alu_r;
    aluif_i.zero      = (alu_r == 32'd0);
    aluif_i.negative  = alu_r[31];
  end

  typedef struct packed {
    logic [31:0] instr, pc, rs1, rs2;
    logic        chk_alu;
    aluop_t      op;
    logic [31:0] b, result;
    logic        wen;
    logic [4:0]  rd;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
  } vec_t;

  int   n_vec = 0, n_err = 0;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {imm, r1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2, input logic chk_alu, input aluop_t op,
                              input logic [31:0] b, result, input logic wen, input logic [4:0] rd,
                              input logic taken, input logic [31:0] target, input logic illegal);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.chk_alu = chk_alu; v.op = op;
    v.b = b; v.result = result; v.wen = wen; v.rd = rd; v.taken = taken; v.target = target;
    v.illegal = illegal;
    return v;
  endfunction

  // Instruction-set semantics of RV32I for the supported subset.
  function automatic vec_t ref_model(input logic [31:0] ins, pc, a, b);
    vec_t        v;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, sh;
    logic [31:0] immi, immb, r;
    logic        ill, is_br, t;
    f7 = ins[31:25]; f3 = ins[14:12]; rd = ins[11:7];
    immi = {{20{ins[31]}}, ins[31:20]};
    immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ill = 1'b0; is_br = 1'b0; t = 1'b0; r = 32'd0; sh = 5'd0;
    case (ins[6:0])
      7'b0110011: begin
        sh = b[4:0];
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: r = a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> sh;
        else ill = 1'b1;
      end
      7'b0010011: begin
        sh = ins[24:20];
        case (f3)
          3'd0: r = a + immi;
          3'd2: r = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
          3'd3: r = (a < immi) ? 32'd1 : 32'd0;
          3'd4: r = a ^ immi;
          3'd6: r = a | immi;
          3'd7: r = a & immi;
          3'd1: if (f7 == 7'h00) r = a << sh; else ill = 1'b1;
          default: if (f7 == 7'h00) r = a >> sh;
                   else if (f7 == 7'h20) r = $signed(a) >>> sh;
                   else ill = 1'b1;
        endcase
      end
      7'b0110111: r = {ins[31:12], 12'b0};
      7'b0010111: r = pc + {ins[31:12], 12'b0};
      7'b1100011: begin
        is_br = 1'b1;
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = !($signed(a) < $signed(b));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    v = '0;
    v.instr = ins; v.pc = pc; v.rs1 = a; v.rs2 = b;
    v.illegal = ill;
    v.taken   = is_br && !ill && t;
    v.target  = pc + immb;
    v.result  = (ill || is_br) ? 32'd0 : r;
    v.wen     = !ill && !is_br && (rd != 5'd0);
    v.rd      = v.wen ? rd : 5'd0;
    return v;
  endfunction

  // Called just after a rising edge with the block idle; returns just after an edge, idle again.
  task automatic run_vec(input vec_t v, input int stall, input string tag);
    chk({tag, " in_ready idle"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc; in_rs1_data = v.rs1; in_rs2_data = v.rs2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " out_valid exec"}, {31'b0, out_valid}, 32'd0);
    if (v.chk_alu) begin
      chk({tag, " alu op"}, {28'b0, aluif_i.op}, {28'b0, v.op});
      chk({tag, " alu inputB"}, aluif_i.inputB, v.b);
    end
    @(posedge clk); #1;
    for (int s = 0; s < stall; s++) begin
      chk({tag, " held valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, " held result"}, out_result, v.result);
      @(posedge clk); #1;
    end
    chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, " result"}, out_result, v.result);
    chk({tag, " wen"}, {31'b0, out_wen}, {31'b0, v.wen});
    if (v.wen) chk({tag, " rd"}, {27'b0, out_rd}, {27'b0, v.rd});
    chk({tag, " br_taken"}, {31'b0, out_br_taken}, {31'b0, v.taken});
    if (v.taken) chk({tag, " br_target"}, out_br_target, v.target);
    chk({tag, " illegal"}, {31'b0, out_illegal}, {31'b0, v.illegal});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef ALU_ISSUE_PERF_EN
    exp_ops++;
    if (v.taken) exp_tk++;
`endif
  endtask

  initial begin
    vec_t v;
    logic [31:0] ins;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h0000_0033; in_pc = '0; in_rs1_data = 32'd1; in_rs2_data = 32'd2;

    tbl[0]  = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h0, 32'd5, 32'd7, 1, ALU_ADD, 32'd7, 32'd12, 1, 5'd3, 0, 32'h0, 0);
    tbl[1]  = mk(enc_i(12'd31, 5'd1, 3'd5, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'hDEAD_BEEF, 1, ALU_SRL, 32'h1F, 32'd1, 1, 5'd4, 0, 32'h0, 0);
    tbl[2]  = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd5), 32'h0, 32'h8000_0000, 32'hFFFF_FF21, 1, ALU_SRL, 32'd1, 32'h4000_0000, 1, 5'd5, 0, 32'h0, 0);
    tbl[3]  = mk(enc_b(13'd16, 5'd2, 5'd1, 3'd0), 32'h100, 32'd9, 32'd9, 1, ALU_SUB, 32'd9, 32'd0, 0, 5'd0, 1, 32'h110, 0);
    tbl[4]  = mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd6), 32'h200, 32'd1, 32'hFFFF_FFFF, 1, ALU_SLTU, 32'hFFFF_FFFF, 32'd0, 0, 5'd0, 1, 32'h1F8, 0);
    tbl[5]  = mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd4), 32'h200, 32'd1, 32'hFFFF_FFFF, 1, ALU_SLT, 32'hFFFF_FFFF, 32'd0, 0, 5'd0, 0, 32'h1F8, 0);
    tbl[6]  = mk(32'h0, 32'h0, 32'd3, 32'd4, 0, ALU_ADD, 32'd0, 32'd0, 0, 5'd0, 0, 32'h0, 1);
    tbl[7]  = mk(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd6), 32'h0, 32'd3, 32'd5, 1, ALU_SUB, 32'd5, 32'hFFFF_FFFE, 1, 5'd6, 0, 32'h0, 0);
    tbl[8]  = mk({20'h12345, 5'd7, 7'b0110111}, 32'h0, 32'h0000_FFFF, 32'd1, 1, ALU_ADD, 32'h1234_5000, 32'h1234_5000, 1, 5'd7, 0, 32'h0, 0);
    tbl[9]  = mk({20'h00001, 5'd8, 7'b0010111}, 32'h1000, 32'd0, 32'd0, 1, ALU_ADD, 32'h1000, 32'h2000, 1, 5'd8, 0, 32'h0, 0);
    tbl[10] = mk(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd9, 7'b0010011), 32'h0, 32'h8000_0000, 32'd0, 1, ALU_SRA, 32'd4, 32'hF800_0000, 1, 5'd9, 0, 32'h0, 0);
    tbl[11] = mk(enc_i(12'hFFF, 5'd1, 3'd0, 5'd10, 7'b0010011), 32'h0, 32'd0, 32'd0, 1, ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 5'd10, 0, 32'h0, 0);
    tbl[12] = mk(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'h0, 32'd5, 32'd7, 1, ALU_ADD, 32'd7, 32'd12, 0, 5'd0, 0, 32'h0, 0);
    tbl[13] = mk(enc_b(13'd16, 5'd2, 5'd1, 3'd2), 32'h40, 32'd1, 32'd1, 0, ALU_ADD, 32'd0, 32'd0, 0, 5'd0, 0, 32'h0, 1);
    tbl[14] = mk(enc_i({7'h01, 5'd3}, 5'd1, 3'd1, 5'd11, 7'b0010011), 32'h0, 32'd1, 32'd0, 0, ALU_ADD, 32'd0, 32'd0, 0, 5'd0, 0, 32'h0, 1);
    tbl[15] = mk(enc_b(13'd4, 5'd2, 5'd1, 3'd5), 32'h300, 32'hFFFF_FFFF, 32'd1, 1, ALU_SLT, 32'd1, 32'd0, 0, 5'd0, 0, 32'h304, 0);
    tbl[16] = mk(enc_b(13'd4, 5'd2, 5'd1, 3'd7), 32'h300, 32'hFFFF_FFFF, 32'd1, 1, ALU_SLTU, 32'd1, 32'd0, 0, 5'd0, 1, 32'h304, 0);
    tbl[17] = mk(enc_b(13'h1FFC, 5'd2, 5'd1, 3'd1), 32'h10, 32'd4, 32'd9, 1, ALU_SUB, 32'd9, 32'd0, 0, 5'd0, 1, 32'hC, 0);

    // Reset state, with in_valid asserted throughout.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst out_result", out_result, 32'd0);
    end
    chk("rst alu op", {28'b0, aluif_i.op}, {28'b0, ALU_ADD});
    in_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("post-rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("post-rst alu inputA", aluif_i.inputA, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) run_vec(tbl[i], i % 3, $sformatf("vec%0d", i));

    // Output held for three cycles while the next op waits, then both handshakes together.
    in_valid = 1'b1; in_instr = tbl[0].instr; in_rs1_data = 32'd5; in_rs2_data = 32'd7;
    @(posedge clk); #1;
    in_instr = tbl[7].instr; in_rs1_data = 32'd3; in_rs2_data = 32'd5;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp result held", out_result, 32'd12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("bp in_ready follows", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp exec out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp exec alu op", {28'b0, aluif_i.op}, {28'b0, ALU_SUB});
    chk("bp exec inputB", aluif_i.inputB, 32'd5);
    @(posedge clk); #1;
    chk("bp 2nd valid", {31'b0, out_valid}, 32'd1);
    chk("bp 2nd result", out_result, 32'hFFFF_FFFE);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp back idle", {31'b0, in_ready}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops += 2;
`endif

    // Reset during EXEC drops the op.
    in_valid = 1'b1; in_instr = tbl[0].instr; in_rs1_data = 32'd5; in_rs2_data = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1; #1;
    chk("mid-rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("mid-rst alu op", {28'b0, aluif_i.op}, {28'b0, ALU_ADD});
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("mid-rst idle", {31'b0, in_ready}, 32'd1);
    chk("mid-rst no valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mid-rst still no valid", {31'b0, out_valid}, 32'd0);
    chk("mid-rst result", out_result, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops = 0; exp_tk = 0;
`endif

    // Randomized instruction mix against the instruction-set model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b, pc;
      int k, p;
      ins = $urandom;
      k = $urandom_range(0, 5);
      p = $urandom_range(0, 3);
      case (k)
        0: begin ins[6:0] = 7'b0110011; if (p < 2) ins[31:25] = 7'h00; else if (p == 2) ins[31:25] = 7'h20; end
        1: begin ins[6:0] = 7'b0010011;
                 if (ins[13:12] == 2'b01) begin
                   if (p < 2) ins[31:25] = 7'h00; else if (p == 2) ins[31:25] = 7'h20;
                 end
           end
        2: ins[6:0] = 7'b0110111;
        3: ins[6:0] = 7'b0010111;
        4: ins[6:0] = 7'b1100011;
        default: ;
      endcase
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      pc = $urandom;
      v = ref_model(ins, pc, a, b);
      run_vec(v, $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_ops", perf_ops, exp_ops);
    chk("perf_br_taken", perf_br_taken, exp_tk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
